// File: rtl/rf_pkg.sv
// Register-file constants shared by the write-port arbiter and its result FIFO.
package rf_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/rf_wb_fifo.sv
// Small in-order FIFO of pending mult/div register writes; every slot's
// valid bit and destination are exposed so the top can build Busy.
module rf_wb_fifo #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             push_i,
   input  logic [ADDR_W-1:0]                push_wn_i,
   input  logic [DATA_W-1:0]                push_wd_i,
   input  logic                             pop_i,
   output logic [ADDR_W-1:0]                head_wn_o,
   output logic [DATA_W-1:0]                head_wd_o,
   output logic                             full_o,
   output logic                             empty_o,
   output logic [PTR_W:0]                   count_o,
   output logic [DEPTH-1:0]                 ent_vld_o,
   output logic [DEPTH-1:0][ADDR_W-1:0]     ent_wn_o
);
   logic [PTR_W:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0]              vld_q, vld_d;
   logic [DEPTH-1:0][ADDR_W-1:0]  wn_q;
   logic [DEPTH-1:0][DATA_W-1:0]  wd_q;

   // Extra pointer MSB separates full (MSBs differ) from empty (equal).
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign count_o   = wr_ptr_q - rd_ptr_q;
   assign head_wn_o = wn_q[rd_ptr_q[PTR_W-1:0]];
   assign head_wd_o = wd_q[rd_ptr_q[PTR_W-1:0]];
   assign ent_vld_o = vld_q;
   assign ent_wn_o  = wn_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      vld_d    = vld_q;
      if (pop_i) begin
         vld_d[rd_ptr_q[PTR_W-1:0]] = 1'b0;
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_i) begin
         vld_d[wr_ptr_q[PTR_W-1:0]] = 1'b1;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         vld_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         vld_q    <= vld_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) begin
         wn_q[wr_ptr_q[PTR_W-1:0]] <= push_wn_i;
         wd_q[wr_ptr_q[PTR_W-1:0]] <= push_wd_i;
      end
   end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the WB stage (fixed priority)
// and queued mult/div results, with starvation stall and busy scoreboard.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4,
   parameter int DATA_W       = REG_DATA_W,
   parameter int ADDR_W       = REG_ADDR_W
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      WB_RegWrite,
   input  logic [ADDR_W-1:0]         WB_WN,
   input  logic [DATA_W-1:0]         WB_WD,
   input  logic                      MD_Valid,
   input  logic [ADDR_W-1:0]         MD_WN,
   input  logic [DATA_W-1:0]         MD_WD,
   output logic                      MD_Ready,
   output logic                      RegWrite,
   output logic [ADDR_W-1:0]         WN,
   output logic [DATA_W-1:0]         WD,
   output logic                      Stall_Req,
   output logic [NUM_REGS-1:0]       Busy,
   output logic [$clog2(DEPTH):0]    Count,
   output logic                      Protocol_Err
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic                          wb_win, push, pop, full, empty;
   logic [ADDR_W-1:0]             head_wn;
   logic [DATA_W-1:0]             head_wd;
   logic [$clog2(DEPTH):0]        fifo_cnt;
   logic [DEPTH-1:0]              ent_vld;
   logic [DEPTH-1:0][ADDR_W-1:0]  ent_wn;
   logic [CNT_W-1:0]              starve_q, starve_d;
   logic                          stall_q, stall_d, perr_q, perr_d;

   rf_wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
      .clk_i     (Clk),
      .rst_i     (Reset),
      .push_i    (push),
      .push_wn_i (MD_WN),
      .push_wd_i (MD_WD),
      .pop_i     (pop),
      .head_wn_o (head_wn),
      .head_wd_o (head_wd),
      .full_o    (full),
      .empty_o   (empty),
      .count_o   (fifo_cnt),
      .ent_vld_o (ent_vld),
      .ent_wn_o  (ent_wn)
   );

   // A WB write to r0 is a non-write, so the FIFO head gets the port.
   assign wb_win   = WB_RegWrite && (WB_WN != ADDR_W'(REG_ZERO));
   assign pop      = !Reset && !wb_win && !empty;
   assign MD_Ready = !Reset && !full;
   // r0 results complete the handshake but are dropped here.
   assign push     = MD_Valid && MD_Ready && (MD_WN != ADDR_W'(REG_ZERO));
   assign Count    = Reset ? '0 : fifo_cnt;

   always_comb begin
      RegWrite = 1'b0;
      WN       = '0;
      WD       = '0;
      if (!Reset) begin
         if (wb_win) begin
            RegWrite = 1'b1;
            WN       = WB_WN;
            WD       = WB_WD;
         end else if (!empty) begin
            RegWrite = 1'b1;
            WN       = head_wn;
            WD       = head_wd;
         end
      end
   end

   always_comb begin
      Busy = '0;
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            for (int r = 1; r < NUM_REGS; r++) begin
               if (ent_vld[i] && ent_wn[i] == ADDR_W'(r)) Busy[r] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (empty || pop)                       starve_d = '0;
      else if (wb_win && starve_q != LIMIT)   starve_d = starve_q + 1'b1;
      stall_d = stall_q;
      if (pop)                       stall_d = 1'b0;
      else if (starve_d == LIMIT)    stall_d = 1'b1;
      perr_d = perr_q || (stall_q && wb_win);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         starve_q <= '0;
         stall_q  <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         starve_q <= starve_d;
         stall_q  <= stall_d;
         perr_q   <= perr_d;
      end
   end

   assign Stall_Req    = stall_q;
   assign Protocol_Err = perr_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed vector table plus randomized traffic, both checked against a
// queue-based model of the arbiter's rules.
module tb_rf_write_arbiter;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        Clk = 1'b0, Reset = 1'b1;
   logic        WB_RegWrite = 1'b0, MD_Valid = 1'b0;
   logic [4:0]  WB_WN = '0, MD_WN = '0;
   logic [31:0] WB_WD = '0, MD_WD = '0;
   logic        MD_Ready, RegWrite, Stall_Req, Protocol_Err;
   logic [4:0]  WN;
   logic [31:0] WD, Busy;
   logic [1:0]  Count;

   rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .DATA_W(32), .ADDR_W(5)) dut (
      .Clk(Clk), .Reset(Reset), .WB_RegWrite(WB_RegWrite), .WB_WN(WB_WN), .WB_WD(WB_WD),
      .MD_Valid(MD_Valid), .MD_WN(MD_WN), .MD_WD(MD_WD), .MD_Ready(MD_Ready),
      .RegWrite(RegWrite), .WN(WN), .WD(WD), .Stall_Req(Stall_Req), .Busy(Busy),
      .Count(Count), .Protocol_Err(Protocol_Err)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic rst, wbw; logic [4:0] wbwn; logic [31:0] wbwd;
      logic mdv; logic [4:0] mdwn; logic [31:0] mdwd;
      logic rw; logic [4:0] wn; logic [31:0] wd;
      logic rdy; logic [1:0] cnt; logic stall, perr; logic [31:0] busy;
   } vec_t;

   typedef struct { logic [4:0] wn; logic [31:0] wd; } ent_t;

   int checks = 0, failures = 0;
   ent_t m_q[$];
   int   m_starve = 0;
   bit   m_stall = 0, m_perr = 0;
   vec_t vt[$];

   function automatic vec_t row(logic rst, logic wbw, logic [4:0] wbwn, logic [31:0] wbwd,
                                logic mdv, logic [4:0] mdwn, logic [31:0] mdwd,
                                logic rw, logic [4:0] wn, logic [31:0] wd, logic rdy,
                                logic [1:0] cnt, logic stall, logic perr, logic [31:0] busy);
      vec_t v;
      v.rst = rst; v.wbw = wbw; v.wbwn = wbwn; v.wbwd = wbwd;
      v.mdv = mdv; v.mdwn = mdwn; v.mdwd = mdwd;
      v.rw = rw; v.wn = wn; v.wd = wd; v.rdy = rdy; v.cnt = cnt;
      v.stall = stall; v.perr = perr; v.busy = busy;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] actual=%h expected=%h", name, idx, act, exp);
      end
   endtask

   // Expected outputs follow directly from the queue contents and the priority rule.
   task automatic model_check(input int idx);
      bit win;
      logic [31:0] busy;
      win = WB_RegWrite && WB_WN != 0;
      busy = 0;
      foreach (m_q[i]) busy |= 32'd1 << m_q[i].wn;
      if (Reset) begin
         chk("model_RegWrite", idx, RegWrite, 0); chk("model_WN", idx, WN, 0);
         chk("model_WD", idx, WD, 0); chk("model_MD_Ready", idx, MD_Ready, 0);
         chk("model_Count", idx, Count, 0); chk("model_Busy", idx, Busy, 0);
      end else begin
         chk("model_RegWrite", idx, RegWrite, (win || m_q.size() > 0) ? 1 : 0);
         chk("model_WN", idx, WN, win ? WB_WN : (m_q.size() > 0 ? m_q[0].wn : 0));
         chk("model_WD", idx, WD, win ? WB_WD : (m_q.size() > 0 ? m_q[0].wd : 0));
         chk("model_MD_Ready", idx, MD_Ready, (m_q.size() < DEPTH) ? 1 : 0);
         chk("model_Count", idx, Count, m_q.size());
         chk("model_Busy", idx, Busy, busy);
      end
      chk("model_Stall_Req", idx, Stall_Req, m_stall);
      chk("model_Protocol_Err", idx, Protocol_Err, m_perr);
   endtask

   task automatic model_update();
      bit win, had, popped;
      ent_t e;
      if (Reset) begin
         m_q.delete(); m_starve = 0; m_stall = 0; m_perr = 0;
         return;
      end
      win = WB_RegWrite && WB_WN != 0;
      had = m_q.size() > 0;
      popped = !win && had;
      if (m_stall && win) m_perr = 1;
      if (MD_Valid && m_q.size() < DEPTH && MD_WN != 0 && !(popped && 0)) begin
         e.wn = MD_WN; e.wd = MD_WD;
         if (popped) void'(m_q.pop_front());
         m_q.push_back(e);
      end else if (popped) void'(m_q.pop_front());
      if (!had || popped) m_starve = 0;
      else if (win && m_starve < LIMIT) m_starve++;
      if (popped) m_stall = 0;
      else if (m_starve == LIMIT) m_stall = 1;
   endtask

   task automatic cycle(input vec_t v, input bit use_exp, input int idx);
      @(negedge Clk);
      Reset = v.rst; WB_RegWrite = v.wbw; WB_WN = v.wbwn; WB_WD = v.wbwd;
      MD_Valid = v.mdv; MD_WN = v.mdwn; MD_WD = v.mdwd;
      #1;
      model_check(idx);
      if (use_exp) begin
         chk("RegWrite", idx, RegWrite, v.rw); chk("WN", idx, WN, v.wn);
         chk("WD", idx, WD, v.wd); chk("MD_Ready", idx, MD_Ready, v.rdy);
         chk("Count", idx, Count, v.cnt); chk("Stall_Req", idx, Stall_Req, v.stall);
         chk("Protocol_Err", idx, Protocol_Err, v.perr); chk("Busy", idx, Busy, v.busy);
      end
      @(posedge Clk);
      model_update();
   endtask

   initial begin
      vec_t v;
      // reset, single MD result
      vt.push_back(row(1,0,0,0,      0,0,0,           0,0,0,          0,0,0,0,0));
      vt.push_back(row(0,0,0,0,      1,3,32'hA5A5A5A5,0,0,0,          1,0,0,0,0));
      vt.push_back(row(0,0,0,0,      0,0,0,           1,3,32'hA5A5A5A5,1,1,0,0,32'h8));
      vt.push_back(row(0,0,0,0,      0,0,0,           0,0,0,          1,0,0,0,0));
      // starvation of r9 behind WB r7
      vt.push_back(row(0,1,7,32'hD1, 1,9,32'h99,      1,7,32'hD1,     1,0,0,0,0));
      vt.push_back(row(0,1,7,32'hD2, 0,0,0,           1,7,32'hD2,     1,1,0,0,32'h200));
      vt.push_back(row(0,1,7,32'hD3, 0,0,0,           1,7,32'hD3,     1,1,0,0,32'h200));
      vt.push_back(row(0,1,7,32'hD4, 0,0,0,           1,7,32'hD4,     1,1,0,0,32'h200));
      vt.push_back(row(0,1,7,32'hD5, 0,0,0,           1,7,32'hD5,     1,1,0,0,32'h200));
      vt.push_back(row(0,0,0,0,      0,0,0,           1,9,32'h99,     1,1,1,0,32'h200));
      vt.push_back(row(0,0,0,0,      0,0,0,           0,0,0,          1,0,0,0,0));
      // fill, back-pressure, drain in order
      vt.push_back(row(0,1,7,32'hE1, 1,10,32'hAA,     1,7,32'hE1,     1,0,0,0,0));
      vt.push_back(row(0,1,7,32'hE2, 1,11,32'hBB,     1,7,32'hE2,     1,1,0,0,32'h400));
      vt.push_back(row(0,1,7,32'hE3, 1,12,32'hCC,     1,7,32'hE3,     0,2,0,0,32'hC00));
      vt.push_back(row(0,0,0,0,      1,12,32'hCC,     1,10,32'hAA,    0,2,0,0,32'hC00));
      vt.push_back(row(0,0,0,0,      1,12,32'hCC,     1,11,32'hBB,    1,1,0,0,32'h800));
      vt.push_back(row(0,0,0,0,      0,0,0,           1,12,32'hCC,    1,1,0,0,32'h1000));
      vt.push_back(row(0,0,0,0,      0,0,0,           0,0,0,          1,0,0,0,0));
      // MD to r0 dropped; WB to r0 yields port to FIFO
      vt.push_back(row(0,0,0,0,      1,0,32'hDEAD,    0,0,0,          1,0,0,0,0));
      vt.push_back(row(0,0,0,0,      0,0,0,           0,0,0,          1,0,0,0,0));
      vt.push_back(row(0,0,0,0,      1,4,32'h44,      0,0,0,          1,0,0,0,0));
      vt.push_back(row(0,1,0,32'hFFFF,0,0,0,          1,4,32'h44,     1,1,0,0,32'h10));
      vt.push_back(row(0,0,0,0,      0,0,0,           0,0,0,          1,0,0,0,0));
      // WB ignores Stall_Req -> sticky Protocol_Err
      vt.push_back(row(0,1,7,32'hF0, 1,5,32'h55,      1,7,32'hF0,     1,0,0,0,0));
      vt.push_back(row(0,1,7,32'hF1, 0,0,0,           1,7,32'hF1,     1,1,0,0,32'h20));
      vt.push_back(row(0,1,7,32'hF2, 0,0,0,           1,7,32'hF2,     1,1,0,0,32'h20));
      vt.push_back(row(0,1,7,32'hF3, 0,0,0,           1,7,32'hF3,     1,1,0,0,32'h20));
      vt.push_back(row(0,1,7,32'hF4, 0,0,0,           1,7,32'hF4,     1,1,0,0,32'h20));
      vt.push_back(row(0,1,7,32'hF5, 0,0,0,           1,7,32'hF5,     1,1,1,0,32'h20));
      vt.push_back(row(0,0,0,0,      0,0,0,           1,5,32'h55,     1,1,1,1,32'h20));
      vt.push_back(row(0,0,0,0,      0,0,0,           0,0,0,          1,0,0,1,0));
      // reset with two entries queued
      vt.push_back(row(0,1,7,32'h61, 1,6,32'h66,      1,7,32'h61,     1,0,0,1,0));
      vt.push_back(row(0,1,7,32'h62, 1,8,32'h88,      1,7,32'h62,     1,1,0,1,32'h40));
      vt.push_back(row(1,1,7,32'h63, 0,0,0,           0,0,0,          0,0,0,1,0));
      vt.push_back(row(0,0,0,0,      0,0,0,           0,0,0,          1,0,0,0,0));

      @(posedge Clk);
      foreach (vt[i]) cycle(vt[i], 1'b1, i);

      for (int n = 0; n < 800; n++) begin
         v = row(($urandom % 60) == 0, ($urandom % 3) != 0, 5'($urandom % 8), $urandom,
                 ($urandom % 2) != 0, 5'($urandom % 8), $urandom,
                 0,0,0,0,0,0,0,0);
         // a well-behaved hazard unit honours Stall_Req most of the time
         if (Stall_Req && ($urandom % 8) != 0) v.wbw = 1'b0;
         cycle(v, 1'b0, 1000 + n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (RegWrite/WN/WD) between two sources: the pipeline WB stage and the multi-cycle mult/div unit.
- WB stage has fixed priority and is never back-pressured.
- Mult/div results enter a small FIFO through a valid/ready handshake. They drain into the register file on cycles when WB does not write.
- A starvation counter raises a stall request to the hazard unit so queued results cannot wait forever. A busy scoreboard tells the hazard unit which registers still have queued writes.

Parameters:
- DEPTH, 2, FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose the port before Stall_Req is raised; at least 1.
- DATA_W, 32, write-data width.
- ADDR_W, 5, register-number width (32 registers).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- WB_RegWrite  in  1  WB stage write enable.
- WB_WN  in  ADDR_W  WB destination register.
- WB_WD  in  DATA_W  WB write data.
- MD_Valid  in  1  mult/div result valid.
- MD_WN  in  ADDR_W  mult/div destination register.
- MD_WD  in  DATA_W  mult/div result data.
- MD_Ready  out  1  FIFO can accept a result this cycle.
- RegWrite  out  1  to the register file's RegWrite.
- WN  out  ADDR_W  to the register file's WN.
- WD  out  DATA_W  to the register file's WD.
- Stall_Req  out  1  registered; asks the hazard unit to bubble WB next cycle.
- Busy  out  32  bit r = 1 means a write to register r is queued.
- Count  out  log2(DEPTH)+1  FIFO occupancy.
- Protocol_Err  out  1  sticky; WB wrote while Stall_Req was high.

Behaviour:
- Reset: FIFO emptied, pointers 0, starvation counter 0, Stall_Req 0, Protocol_Err 0.
  - While Reset is high: RegWrite=0, WN=0, WD=0, MD_Ready=0, Busy=0, Count=0.
- Port select (combinational, every cycle):
  - WB_RegWrite=1 and WB_WN!=0: WB wins; RegWrite=1, WN=WB_WN, WD=WB_WD.
  - Otherwise, FIFO non-empty: head is popped at this edge; RegWrite=1, WN/WD = head fields.
  - Otherwise: RegWrite=0, WN=0, WD=0.
  - A WB write to register 0 is treated as no write; the port goes to the FIFO head that cycle.
- Enqueue:
  - MD_Ready = !full (no pop-through when full).
  - Push occurs on an edge where MD_Valid and MD_Ready are both 1.
  - If MD_WN=0 the handshake completes and the entry is discarded. No FIFO entry ever targets register 0.
  - Simultaneous push and pop is allowed when not full; Count is unchanged.
- Latency: a result accepted at edge k appears on the write port in cycle k+1 at the earliest. There is no MD-to-port bypass.
- Ordering: FIFO entries drain in arrival order. WAW between WB and queued MD writes is prevented by the hazard unit using Busy; the arbiter does no reordering.
- Starvation counter:
  - Increments at each edge where the FIFO is non-empty and WB wins.
  - Clears to 0 on any pop, or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Stall_Req:
  - Set at the edge where the counter reaches STARVE_LIMIT.
  - Cleared at the edge where a pop occurs.
- Protocol_Err: if Stall_Req=1 and WB still writes, WB still wins and Protocol_Err is set. It clears only on Reset.
- Busy: OR over valid FIFO entries of the one-hot decode of their WN. Bit 0 is always 0.
- Wrap-around: read and write pointers wrap modulo DEPTH; an extra pointer MSB distinguishes full from empty.
- Reset mid-operation: queued entries are lost; MD_Ready stays 0 until the cycle after Reset deasserts.

Decomposition:
- Shared package (rf_pkg): REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, REG_ZERO=5'd0.
- One sub-module: rf_wb_fifo, a synchronous FIFO with push/pop/full/empty/count that exposes all entries for the Busy decode. The arbitration, starvation logic and error flag stay in the top.

Test Plan:
- Reset, then MD result (MD_WN=3, MD_WD=32'hA5A5A5A5) with WB idle -> MD_Ready=1 at the push edge; next cycle RegWrite=1, WN=3, WD=A5A5A5A5; Busy[3] is 1 for exactly one cycle.
- WB writing register 7 every cycle while MD pushes register 9 -> no pop; Stall_Req rises after 4 losing cycles. Then drop WB_RegWrite -> register 9 is written that cycle; Stall_Req clears at the next edge.
- Push 2 results with WB busy -> Count=2, MD_Ready=0; a third MD_Valid is held. Release WB -> pops in order, then the third result is accepted.
- MD_WN=0, and separately WB_WN=0 with WB_RegWrite=1 and a queued entry for register 4 -> first: nothing queued, Count stays 0; second: register 4 is written.
- Stall_Req=1 and WB_RegWrite=1 -> WB wins and Protocol_Err=1, which persists until Reset.
- Assert Reset with 2 entries queued -> next cycle Count=0, Busy=0, RegWrite=0, Stall_Req=0.
